// File: rtl/vram_arbiter.sv
// Round-robin arbiter sharing one VRAM port among NUM_REQ graphics requesters,
// with per-requester lock for read-modify-write and an ack watchdog.
module vram_arbiter #(
    parameter int unsigned NUM_REQ        = 3,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic                    clk,
    input  logic                    reset_i,
    input  logic [NUM_REQ-1:0]      req_sel_i,
    input  logic [NUM_REQ-1:0]      req_wr_i,
    input  logic [NUM_REQ-1:0]      req_lock_i,
    input  logic [4*NUM_REQ-1:0]    req_mask_i,
    input  logic [32*NUM_REQ-1:0]   req_addr_i,
    input  logic [16*NUM_REQ-1:0]   req_data_i,
    output logic [NUM_REQ-1:0]      req_ack_o,
    output logic [NUM_REQ-1:0]      req_err_o,
    output logic [15:0]             req_data_o,
    output logic [NUM_REQ-1:0]      grant_o,
    input  logic                    vram_ack_i,
    output logic                    vram_sel_o,
    output logic                    vram_wr_o,
    output logic [3:0]              vram_mask_o,
    output logic [31:0]             vram_addr_o,
    input  logic [15:0]             vram_data_in_i,
    output logic [15:0]             vram_data_out_o
);

    localparam int unsigned PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    typedef struct packed {
        logic        wr;
        logic [3:0]  mask;
        logic [31:0] addr;
        logic [15:0] data;
    } vram_cmd_t;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ISSUE   = 2'd1,
        ST_RELEASE = 2'd2,
        ST_LOCKED  = 2'd3
    } state_e;

    state_e              state_q, state_d;
    logic [PW-1:0]       ptr_q, ptr_d;
    logic [PW-1:0]       own_q, own_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic                tmo_q, tmo_d;
    vram_cmd_t           cmd_q, cmd_d;
    logic                sel_q, sel_d;
    logic [NUM_REQ-1:0]  grant_q, grant_d;
    logic [NUM_REQ-1:0]  ack_q, ack_d;
    logic [NUM_REQ-1:0]  err_q, err_d;
    logic [15:0]         rdata_q, rdata_d;

    logic                win_any_c;
    logic [PW-1:0]       win_idx_c;
    int                  best_c;
    int                  dist_c;
    logic                own_sel_c;
    logic                own_lock_c;
    logic                tmo_hit_c;
    logic                issue_c;
    logic                release_c;
    logic [PW-1:0]       iss_idx_c;
    logic [PW-1:0]       ptr_next_c;
    vram_cmd_t           iss_cmd_c;

    // Round-robin winner: requester with the smallest circular distance from ptr.
    always_comb begin
        win_any_c = 1'b0;
        win_idx_c = '0;
        best_c    = int'(NUM_REQ);
        dist_c    = 0;
        for (int k = 0; k < int'(NUM_REQ); k++) begin
            dist_c = (k >= int'(ptr_q)) ? (k - int'(ptr_q))
                                        : (k + int'(NUM_REQ) - int'(ptr_q));
            if (req_sel_i[k] && (dist_c < best_c)) begin
                best_c    = dist_c;
                win_any_c = 1'b1;
                win_idx_c = PW'(k);
            end
        end
    end

    always_comb begin
        own_sel_c  = req_sel_i[own_q];
        own_lock_c = req_lock_i[own_q];
        tmo_hit_c  = (TIMEOUT_CYCLES != 0) && (cnt_q == CW'(TIMEOUT_CYCLES - 1));
        issue_c    = ((state_q == ST_IDLE) && win_any_c) ||
                     ((state_q == ST_LOCKED) && own_sel_c);
        // A timed-out transaction never keeps the port, whatever its lock says.
        release_c  = ((state_q == ST_RELEASE) && !(own_lock_c && !tmo_q)) ||
                     ((state_q == ST_LOCKED) && !own_sel_c && !own_lock_c);
        iss_idx_c  = (state_q == ST_LOCKED) ? own_q : win_idx_c;
        ptr_next_c = (own_q == PW'(NUM_REQ - 1)) ? '0 : (own_q + PW'(1));
    end

    // Payload mux for the requester being issued.
    always_comb begin
        iss_cmd_c = '0;
        for (int k = 0; k < int'(NUM_REQ); k++) begin
            if (PW'(k) == iss_idx_c) begin
                iss_cmd_c.wr   = req_wr_i[k];
                iss_cmd_c.mask = req_mask_i[4*k +: 4];
                iss_cmd_c.addr = req_addr_i[32*k +: 32];
                iss_cmd_c.data = req_data_i[16*k +: 16];
            end
        end
    end

    // State register.
    always_ff @(posedge clk or negedge reset_i) begin
        if (!reset_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (win_any_c) state_d = ST_ISSUE;
            end
            ST_ISSUE: begin
                if (vram_ack_i || tmo_hit_c) state_d = ST_RELEASE;
            end
            ST_RELEASE: begin
                state_d = (own_lock_c && !tmo_q) ? ST_LOCKED : ST_IDLE;
            end
            ST_LOCKED: begin
                if (own_sel_c) begin
                    state_d = ST_ISSUE;
                end else if (!own_lock_c) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Output and datapath next values.
    always_comb begin
        cmd_d   = cmd_q;
        sel_d   = sel_q;
        grant_d = grant_q;
        ack_d   = '0;
        err_d   = '0;
        rdata_d = rdata_q;
        own_d   = own_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        tmo_d   = tmo_q;

        if (issue_c) begin
            cmd_d   = iss_cmd_c;
            sel_d   = 1'b1;
            grant_d = NUM_REQ'(1) << iss_idx_c;
            own_d   = iss_idx_c;
            cnt_d   = '0;
            tmo_d   = 1'b0;
        end

        if (state_q == ST_ISSUE) begin
            if (vram_ack_i) begin
                sel_d        = 1'b0;
                ack_d[own_q] = 1'b1;
                rdata_d      = vram_data_in_i;
            end else if (tmo_hit_c) begin
                sel_d        = 1'b0;
                ack_d[own_q] = 1'b1;
                err_d[own_q] = 1'b1;
                rdata_d      = '0;
                tmo_d        = 1'b1;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end

        if (release_c) begin
            grant_d = '0;
            ptr_d   = ptr_next_c;
        end
    end

    // Datapath and output registers.
    always_ff @(posedge clk or negedge reset_i) begin
        if (!reset_i) begin
            cmd_q   <= '{wr: 1'b0, mask: 4'hF, addr: 32'h0, data: 16'h0};
            sel_q   <= 1'b0;
            grant_q <= '0;
            ack_q   <= '0;
            err_q   <= '0;
            rdata_q <= '0;
            own_q   <= '0;
            ptr_q   <= '0;
            cnt_q   <= '0;
            tmo_q   <= 1'b0;
        end else begin
            cmd_q   <= cmd_d;
            sel_q   <= sel_d;
            grant_q <= grant_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
            own_q   <= own_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            tmo_q   <= tmo_d;
        end
    end

    assign req_ack_o       = ack_q;
    assign req_err_o       = err_q;
    assign req_data_o      = rdata_q;
    assign grant_o         = grant_q;
    assign vram_sel_o      = sel_q;
    assign vram_wr_o       = cmd_q.wr;
    assign vram_mask_o     = cmd_q.mask;
    assign vram_addr_o     = cmd_q.addr;
    assign vram_data_out_o = cmd_q.data;

endmodule
